// File: rtl/mc_rv32_cpu.sv
`default_nettype none
// ============================================================================
// Module   : mc_rv32_cpu
// Purpose  : Multi-cycle RV32I core (no M extension) with a single shared
//            req/ack memory port.  Each instruction walks
//            FETCH -> DECODE -> EXEC -> [MEM] -> [WB].  ECALL/EBREAK park the
//            core in HALT; undecodable words and misaligned accesses/targets
//            park it in TRAP.  Only reset leaves either state.
// Ports    : clk, reset     - clock (rising edge), async active-high reset
//            mem_*          - shared fetch/load/store port; req is held with
//                             stable addr/we/wdata until the ack edge
//            PC_out         - PC of the instruction in progress
//            reg_sel/data   - combinational debug read of x[reg_sel]
//            retire         - one-cycle pulse per completed instruction
//            halted/illegal - sticky HALT / TRAP status
// Revision : 1.0 - initial release
// ============================================================================
module mc_rv32_cpu #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          TRAP_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] PC_out,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data,
  output logic        retire,
  output logic        halted,
  output logic        illegal
);

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB    = 3'd4, S_HALT   = 3'd5, S_TRAP = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
  logic        retire_q, retire_d, halted_q, illegal_q;
  logic [31:0] regs_q [32];

  // Instruction fields (IR is stable from DECODE until the next FETCH ack).
  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_lw, is_sw, is_op, is_sys;
  assign is_lui   = (opcode == OPC_LUI);
  assign is_auipc = (opcode == OPC_AUIPC);
  assign is_jal   = (opcode == OPC_JAL);
  assign is_jalr  = (opcode == OPC_JALR);
  assign is_br    = (opcode == OPC_BRANCH);
  assign is_lw    = (opcode == OPC_LOAD);
  assign is_sw    = (opcode == OPC_STORE);
  assign is_op    = (opcode == OPC_OP);
  assign is_sys   = (opcode == OPC_SYSTEM);

  logic legal;
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
      OPC_JALR:                    legal = (f3 == 3'b000);
      OPC_BRANCH:                  legal = (f3[2:1] != 2'b01);
      OPC_LOAD, OPC_STORE:         legal = (f3 == 3'b010);
      OPC_OPIMM: begin
        case (f3)
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OPC_OP: legal = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OPC_SYSTEM: legal = (ir_q == INSN_ECALL) || (ir_q == INSN_EBREAK);
      default:    legal = 1'b0;
    endcase
  end

  logic [31:0] imm_dec;
  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm_dec = {ir_q[31:12], 12'b0};
      OPC_JAL:    imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      OPC_BRANCH: imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OPC_STORE:  imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      default:    imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  logic [31:0] rs1_val, rs2_val;
  assign rs1_val  = (rs1 == 5'd0)     ? 32'd0 : regs_q[rs1];
  assign rs2_val  = (rs2 == 5'd0)     ? 32'd0 : regs_q[rs2];
  assign reg_data = (reg_sel == 5'd0) ? 32'd0 : regs_q[reg_sel];

  // ALU shared by OP and OP-IMM; ir[30] selects SUB (OP only) and SRA/SRAI.
  logic [31:0] op2, alu_res;
  logic [4:0]  shamt;
  assign op2   = is_op ? b_q : imm_q;
  assign shamt = op2[4:0];
  always_comb begin
    case (f3)
      3'b000:  alu_res = (is_op && ir_q[30]) ? (a_q - op2) : (a_q + op2);
      3'b001:  alu_res = a_q << shamt;
      3'b010:  alu_res = {31'd0, $signed(a_q) < $signed(op2)};
      3'b011:  alu_res = {31'd0, a_q < op2};
      3'b100:  alu_res = a_q ^ op2;
      3'b101:  alu_res = ir_q[30] ? 32'($signed(a_q) >>> shamt) : (a_q >> shamt);
      3'b110:  alu_res = a_q | op2;
      default: alu_res = a_q & op2;
    endcase
  end

  logic taken;
  always_comb begin
    case (f3)
      3'b000:  taken = (a_q == b_q);
      3'b001:  taken = (a_q != b_q);
      3'b100:  taken = ($signed(a_q) <  $signed(b_q));
      3'b101:  taken = ($signed(a_q) >= $signed(b_q));
      3'b110:  taken = (a_q <  b_q);
      3'b111:  taken = (a_q >= b_q);
      default: taken = 1'b0;
    endcase
  end

  // EXEC result: data address for LW/SW, jump target for JAL/JALR.
  logic [31:0] exec_raw, exec_val, br_raw, br_tgt, pc_plus4, wb_val;
  logic        is_addr, misalign;
  always_comb begin
    if (is_lui)                  exec_raw = imm_q;
    else if (is_auipc || is_jal) exec_raw = pc_q + imm_q;
    else if (is_jalr)            exec_raw = (a_q + imm_q) & ~32'd1;
    else if (is_lw || is_sw)     exec_raw = a_q + imm_q;
    else                         exec_raw = alu_res;
  end
  assign is_addr  = is_lw || is_sw || is_jal || is_jalr;
  assign exec_val = (is_addr && !TRAP_MISALIGN) ? {exec_raw[31:2], 2'b00} : exec_raw;
  assign br_raw   = pc_q + imm_q;
  assign br_tgt   = TRAP_MISALIGN ? br_raw : {br_raw[31:2], 2'b00};
  assign misalign = TRAP_MISALIGN &&
                    ((is_addr && (exec_raw[1:0] != 2'b00)) ||
                     (is_br && taken && (br_raw[1:0] != 2'b00)));
  assign pc_plus4 = pc_q + 32'd4;
  assign wb_val   = (is_jal || is_jalr) ? pc_plus4 : (is_lw ? mdr_q : alu_q);

  // Next-state and memory-port outputs. Requests are masked during reset so
  // the port is quiet while the core is held.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retire_d  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = b_q;
    case (state_q)
      S_FETCH: begin
        mem_req = !reset;
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!legal)      state_d = S_TRAP;
        else if (is_sys) state_d = S_HALT;
        else             state_d = S_EXEC;
      end
      S_EXEC: begin
        if (misalign) begin
          state_d = S_TRAP;
        end else if (is_br) begin
          pc_d     = taken ? br_tgt : pc_plus4;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = !reset;
        mem_we   = is_sw && !reset;
        mem_addr = alu_q;
        if (mem_ack) begin
          if (is_sw) begin
            pc_d     = pc_plus4;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        pc_d     = (is_jal || is_jalr) ? alu_q : pc_plus4;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retire_q  <= retire_d;
      halted_q  <= (state_d == S_HALT);
      illegal_q <= (state_d == S_TRAP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ack) ir_q <= mem_rdata;
        S_DECODE: begin
          a_q   <= rs1_val;
          b_q   <= rs2_val;
          imm_q <= imm_dec;
        end
        S_EXEC:   alu_q <= exec_val;
        S_MEM:    if (mem_ack && !is_sw) mdr_q <= mem_rdata;
        S_WB:     if (rd != 5'd0) regs_q[rd] <= wb_val;
        default:  ;
      endcase
    end
  end

  assign PC_out  = pc_q;
  assign retire  = retire_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_rv32_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_rv32_cpu
// Purpose  : Directed programs for mc_rv32_cpu against a word memory with a
//            programmable number of wait cycles per transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_rv32_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, PC_out, reg_data;
  logic [4:0]  reg_sel = 5'd0;
  logic        retire, halted, illegal;

  always #5 clk = ~clk;

  mc_rv32_cpu #(.RESET_PC(32'h0000_0000), .TRAP_MISALIGN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .PC_out(PC_out), .reg_sel(reg_sel), .reg_data(reg_data),
    .retire(retire), .halted(halted), .illegal(illegal)
  );

  // Memory: 256 words, ack after wait_n cycles of held request.
  logic [31:0] mem [256];
  int          wait_n = 0;
  int          cnt = 0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = 8'd0;
  logic [31:0] ld_word = 32'd0;

  assign mem_ack   = mem_req && (cnt == wait_n);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_word;
    else if (mem_req && mem_ack && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    if (!mem_req || mem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  // Bus / retire monitor
  logic        mon_clr = 1'b1;
  int          cyc, n_ret, n_wr, n_xfer, n_req, run, last_run, n_unstable;
  int          ret_cyc [16];
  logic        prev_req, prev_we;
  logic [31:0] prev_addr, prev_wdata, wr_addr, wr_data;

  always @(negedge clk) begin
    if (mon_clr) begin
      cyc = 0; n_ret = 0; n_wr = 0; n_xfer = 0; n_req = 0;
      run = 0; last_run = 0; n_unstable = 0; prev_req = 1'b0;
    end else begin
      cyc++;
      if (retire) begin
        if (n_ret < 16) ret_cyc[n_ret] = cyc;
        n_ret++;
      end
      if (mem_req) begin
        n_req++;
        run++;
        if (prev_req && (mem_addr != prev_addr || mem_we != prev_we || mem_wdata != prev_wdata))
          n_unstable++;
      end
      if (mem_req && mem_ack) begin
        n_xfer++;
        last_run = run;
        run = 0;
        if (mem_we) begin
          n_wr++;
          wr_addr = mem_addr;
          wr_data = mem_wdata;
        end
      end
      prev_req   = mem_req && !mem_ack;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
    reg_sel = 5'(r);
    #1;
    check(tag, reg_data, exp);
  endtask

  // Holds the core in reset, loads six words at address 0 and zeroes the rest
  // of the first 32 words.
  task automatic load_prog(input logic [31:0] w0, w1, w2, w3, w4, w5, input int waits);
    logic [31:0] w [6];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4; w[5] = w5;
    reset   = 1'b1;
    mon_clr = 1'b1;
    wait_n  = waits;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_idx  = 8'(i);
      ld_word = (i < 6) ? w[i] : 32'h0;
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_to_stop(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    reset   = 1'b0;
    mon_clr = 1'b0;
    while (!(halted || illegal) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_stop_in_budget"}, 32'(n < budget), 32'd1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc",      PC_out,          32'h0);
    check("rst_req",     32'(mem_req),    32'd0);
    check("rst_we",      32'(mem_we),     32'd0);
    check("rst_retire",  32'(retire),     32'd0);
    check("rst_halted",  32'(halted),     32'd0);
    check("rst_illegal", 32'(illegal),    32'd0);

    // addi x1,x0,5; addi x2,x1,-7; add x3,x1,x2; ecall -- zero wait
    load_prog(32'h00500093, 32'hFF908113, 32'h002081B3, 32'h00000073, 32'h0, 32'h0, 0);
    run_to_stop("t1", 200);
    chk_reg("t1_x1", 1, 32'd5);
    chk_reg("t1_x2", 2, 32'hFFFF_FFFE);
    chk_reg("t1_x3", 3, 32'd3);
    check("t1_nret",   32'(n_ret), 32'd3);
    check("t1_gap1",   32'(ret_cyc[1] - ret_cyc[0]), 32'd4);
    check("t1_gap2",   32'(ret_cyc[2] - ret_cyc[1]), 32'd4);
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_pc",     PC_out, 32'h0000_000C);
    check("t1_nreq",   32'(n_req), 32'd4);

    // Same program, 2 wait cycles per transfer
    load_prog(32'h00500093, 32'hFF908113, 32'h002081B3, 32'h00000073, 32'h0, 32'h0, 2);
    run_to_stop("t2", 400);
    chk_reg("t2_x1", 1, 32'd5);
    chk_reg("t2_x2", 2, 32'hFFFF_FFFE);
    chk_reg("t2_x3", 3, 32'd3);
    check("t2_gap1",     32'(ret_cyc[1] - ret_cyc[0]), 32'd6);
    check("t2_gap2",     32'(ret_cyc[2] - ret_cyc[1]), 32'd6);
    check("t2_req_len",  32'(last_run), 32'd3);
    check("t2_stable",   32'(n_unstable), 32'd0);
    check("t2_nreq",     32'(n_req), 32'd12);
    check("t2_pc",       PC_out, 32'h0000_000C);

    // lui x5,0x12345; sw x5,0x40(x0); lw x6,0x40(x0); ecall
    load_prog(32'h123452B7, 32'h04502023, 32'h04002303, 32'h00000073, 32'h0, 32'h0, 0);
    run_to_stop("t3", 200);
    check("t3_nwr",    32'(n_wr), 32'd1);
    check("t3_waddr",  wr_addr, 32'h0000_0040);
    check("t3_wdata",  wr_data, 32'h1234_5000);
    chk_reg("t3_x5", 5, 32'h1234_5000);
    chk_reg("t3_x6", 6, 32'h1234_5000);
    check("t3_sw_lat", 32'(ret_cyc[1] - ret_cyc[0]), 32'd4);
    check("t3_lw_lat", 32'(ret_cyc[2] - ret_cyc[1]), 32'd5);

    // addi x1,x0,-1; bltu x0,x1,+8; addi x2,x0,1; jal x3,+8; .word -1; ecall
    load_prog(32'hFFF00093, 32'h00106463, 32'h00100113, 32'h008001EF, 32'hFFFF_FFFF, 32'h00000073, 0);
    run_to_stop("t4", 200);
    chk_reg("t4_x1", 1, 32'hFFFF_FFFF);
    chk_reg("t4_x2", 2, 32'd0);
    chk_reg("t4_x3", 3, 32'h0000_0010);
    check("t4_halted",  32'(halted), 32'd1);
    check("t4_illegal", 32'(illegal), 32'd0);
    check("t4_pc",      PC_out, 32'h0000_0014);
    check("t4_br_lat",  32'(ret_cyc[1] - ret_cyc[0]), 32'd3);
    check("t4_nret",    32'(n_ret), 32'd3);

    // nop; .word 0xFFFFFFFF -> trap, then asynchronous reset out of TRAP
    load_prog(32'h00000013, 32'hFFFF_FFFF, 32'h00000073, 32'h0, 32'h0, 32'h0, 0);
    run_to_stop("t5", 200);
    check("t5_illegal", 32'(illegal), 32'd1);
    check("t5_halted",  32'(halted), 32'd0);
    check("t5_pc",      PC_out, 32'h0000_0004);
    check("t5_nreq",    32'(n_req), 32'd2);
    check("t5_nret",    32'(n_ret), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_illegal", 32'(illegal), 32'd0);
    check("t5_rst_pc",      PC_out, 32'h0);
    check("t5_rst_req",     32'(mem_req), 32'd0);

    // Reset in the middle of a waited fetch
    begin
      int n = 0;
      load_prog(32'h00500093, 32'hFF908113, 32'h002081B3, 32'h00000073, 32'h0, 32'h0, 3);
      @(negedge clk);
      reset   = 1'b0;
      mon_clr = 1'b0;
      while (!retire && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("t6_first_retire", 32'(n < 100), 32'd1);
      check("t6_fetch_req",    32'(mem_req), 32'd1);
      check("t6_fetch_pc",     PC_out, 32'h0000_0004);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_pc",     PC_out, 32'h0);
      check("t6_rst_req",    32'(mem_req), 32'd0);
      check("t6_rst_retire", 32'(retire), 32'd0);
    end

    // addi x1,x0,2; lw x2,0(x1) -> misaligned load traps without data access
    load_prog(32'h00200093, 32'h0000A103, 32'h00000073, 32'h0, 32'h0, 32'h0, 0);
    run_to_stop("t7", 200);
    check("t7_illegal", 32'(illegal), 32'd1);
    check("t7_halted",  32'(halted), 32'd0);
    check("t7_pc",      PC_out, 32'h0000_0004);
    check("t7_nxfer",   32'(n_xfer), 32'd2);
    chk_reg("t7_x1", 1, 32'd2);
    chk_reg("t7_x2", 2, 32'd0);

    // addi x0,x0,9; ecall -> x0 stays zero; reset cleared x1 from before
    load_prog(32'h00900013, 32'h00000073, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    run_to_stop("t8", 200);
    chk_reg("t8_x0", 0, 32'd0);
    chk_reg("t8_x1", 1, 32'd0);
    check("t8_halted", 32'(halted), 32'd1);
    check("t8_nret",   32'(n_ret), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_rv32_cpu.md
Name: mc_rv32_cpu

Overview:
- Multi-cycle successor to the team's single-cycle RV32 core.
- Replaces the fixed one-cycle instruction/data ports with a single shared memory port using a req/ack handshake, so memories with wait states are supported.
- Adds halt, trap and retire status.
- Sits between the SoC memory mux and the debug/board logic; exposes the same register-debug readout.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- TRAP_MISALIGN, 1: 1 = misaligned word load/store or jump target traps; 0 = address[1:0] forced to 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request; held until acked.
- mem_we  out  1  1 = write (store), 0 = read (fetch/load).
- mem_addr  out  32  byte address.
- mem_wdata  out  32  store data (rs2 value).
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  transfer completes at the rising edge where mem_req&mem_ack.
- PC_out  out  32  PC of the instruction in progress.
- reg_sel  in  5  debug register select.
- reg_data  out  32  combinational read of x[reg_sel]; x0 reads 0.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  sticky; set by ECALL/EBREAK.
- illegal  out  1  sticky; set by undecodable opcode or misalignment trap.

Behaviour:
- Reset (async, immediate): PC=RESET_PC, state=FETCH, x1..x31=0, IR=0; mem_req=0, mem_we=0, retire=0, halted=0, illegal=0. Reset mid-transfer aborts it; the memory side must tolerate a dropped req.
- Supported ops: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, all OP-IMM, all OP (RV32I, no M), ECALL/EBREAK. Any other opcode/funct combination is illegal.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ack, IR<=mem_rdata, go to DECODE.
  - DECODE: A<=x[rs1], B<=x[rs2], imm<=sign-extended immediate per format.
    - Illegal -> TRAP.
    - ECALL/EBREAK -> HALT.
    - Otherwise -> EXEC.
  - EXEC: ALUout<=result; branch condition evaluated.
    - Branch: PC<=taken ? PC+immB : PC+4; retire; -> FETCH.
    - LW/SW -> MEM.
    - Others -> WB.
  - MEM: mem_req=1, mem_addr=ALUout, mem_we=(SW), mem_wdata=B. On ack:
    - LW: MDR<=mem_rdata; -> WB.
    - SW: PC<=PC+4; retire; -> FETCH.
  - WB: x[rd]<=value (ALUout, MDR, or PC+4 for JAL/JALR); writes to rd=0 are discarded.
    - PC<=PC+4, or target for JAL (PC+immJ) / JALR ((rs1+immI)&~1).
    - retire; -> FETCH.
  - HALT: halted=1, no requests, PC frozen; exit only by reset.
  - TRAP: illegal=1, no requests, PC frozen at the faulting instruction; exit only by reset.
- Latency with zero-wait memory (ack in the same cycle as req), cycles from FETCH entry to retire: branch 3, SW 4, ALU/LUI/AUIPC/JAL/JALR 4, LW 5. Each memory wait cycle adds 1.
- Handshake rules:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable from req assertion through the ack edge.
  - mem_req=0 in DECODE, EXEC, WB, HALT and TRAP.
  - At most one outstanding transfer.
- Misalignment with TRAP_MISALIGN=1: LW/SW address[1:0]!=0, or a JAL/JALR/taken-branch target with [1:0]!=0, -> TRAP from EXEC, with no memory access and no register write.
- Arithmetic:
  - All 32-bit, wrap-around; SLT/SLTI signed, SLTU/SLTIU unsigned.
  - Shifts use the low 5 bits of the amount; SRA/SRAI arithmetic.
  - JALR with rd==rs1 uses the old rs1 value.
- retire is high for exactly the cycle after the state-transition edge that completes an instruction; never high in HALT or TRAP.

Test Plan:
- Zero-wait memory, program "addi x1,x0,5; addi x2,x1,-7; add x3,x1,x2; ecall" -> x1=5, x2=0xFFFFFFFE, x3=3; 3 retire pulses at 4-cycle spacing; halted=1; PC_out frozen at ecall address 0x0C.
- Same program with a 2-cycle wait on every ack -> identical register results; fetch requests held stable for 3 cycles each, 6 cycles between retires.
- "lui x5,0x12345; sw x5,0x40(x0); lw x6,0x40(x0)" -> write at 0x40 with data 0x12345000; x6=0x12345000; LW takes 5 cycles zero-wait.
- "addi x1,x0,-1; bltu x0,x1,+8; addi x2,x0,1; jal x3,+8" -> branch taken (unsigned), x2 stays 0, x3=PC_of_jal+4.
- Word 0xFFFFFFFF fetched -> illegal=1 after DECODE, no further mem_req; assert reset mid-FETCH of the next run -> PC=RESET_PC, illegal=0 immediately.
- "addi x1,x0,2; lw x2,0(x1)" with TRAP_MISALIGN=1 -> illegal=1, no data request, x2 unchanged; writes to x0 (addi x0,x0,9) leave reg_data(x0)=0.
